display_timing: RTL and testbench

//  Parametrised raster timing generator; replaces the fixed-mode display block.

---
 rtl/display_timing.sv | 271 +++++++++++++++++++++++++++
 tb/tb_display_timing.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timing.sv
// ---------------------------------------------------------------------------
// display_timing
//   Parametrised raster timing generator. Walks col/row over an
//   H_TOTAL x V_TOTAL frame on pixelclk. Flags the active, front porch, sync
//   and back porch regions, and drives polarity-corrected sync pins and
//   frame/line strobes. A new timing can be loaded at runtime through a
//   valid/ready handshake. It is held in a shadow register and only becomes
//   active at the next frame boundary.
//
// Ports
//   pixelclk        : pixel clock, the only clock
//   rst_n           : synchronous reset, active-low
//   en              : 1 = advance one pixel per clock, 0 = hold everything
//   cfg_valid       : new timing offered on cfg_h_* / cfg_v_*
//   cfg_ready       : shadow register empty, a cfg may be accepted
//   cfg_h_*/cfg_v_* : new horizontal / vertical timing fields
//   cfg_err         : one-cycle pulse, offered cfg was rejected
//   hfront..vback   : region flags, active-high
//   indisplay       : pixel lies inside the visible area
//   hsync_pin       : hsync with HSYNC_POL applied
//   vsync_pin       : vsync with VSYNC_POL applied
//   frame_start     : pulse at (0,0)
//   line_start      : pulse at col 0
//   row, col        : current raster position
// ---------------------------------------------------------------------------
module display_timing #(
  parameter int unsigned W         = 16,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic         pixelclk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_h_active,
  input  logic [W-1:0] cfg_h_front,
  input  logic [W-1:0] cfg_h_sync,
  input  logic [W-1:0] cfg_h_back,
  input  logic [W-1:0] cfg_v_active,
  input  logic [W-1:0] cfg_v_front,
  input  logic [W-1:0] cfg_v_sync,
  input  logic [W-1:0] cfg_v_back,
  output logic         cfg_err,
  output logic         hfront,
  output logic         hsync,
  output logic         hback,
  output logic         vfront,
  output logic         vsync,
  output logic         vback,
  output logic         indisplay,
  output logic         hsync_pin,
  output logic         vsync_pin,
  output logic         frame_start,
  output logic         line_start,
  output logic [W-1:0] row,
  output logic [W-1:0] col
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W+1:0] TOTAL_MAX = {2'b00, {W{1'b1}}};

  typedef struct packed {
    logic [W-1:0] ha;
    logic [W-1:0] hf;
    logic [W-1:0] hs;
    logic [W-1:0] hb;
    logic [W-1:0] va;
    logic [W-1:0] vf;
    logic [W-1:0] vs;
    logic [W-1:0] vb;
  } timing_t;

  localparam timing_t DEF_TIMING = '{
    ha: W'(H_ACTIVE), hf: W'(H_FRONT), hs: W'(H_SYNC), hb: W'(H_BACK),
    va: W'(V_ACTIVE), vf: W'(V_FRONT), vs: W'(V_SYNC), vb: W'(V_BACK)
  };

  logic [0:0]   state_q, state_d;
  logic [W-1:0] row_q, row_d, col_q, col_d;
  timing_t      act_q, act_d, shd_q, shd_d, cfg_in;
  logic         cfg_ready_q, cfg_ready_d;
  logic         cfg_err_q, cfg_err_d;
  logic         hfront_q, hfront_d, hsync_q, hsync_d, hback_q, hback_d;
  logic         vfront_q, vfront_d, vsync_q, vsync_d, vback_q, vback_d;
  logic         indisplay_q, indisplay_d;
  logic         hsync_pin_q, hsync_pin_d, vsync_pin_q, vsync_pin_d;
  logic         frame_start_q, frame_start_d, line_start_q, line_start_d;
  logic         new_frame;

  logic [W+1:0] cfg_h_total, cfg_v_total;
  logic         cfg_ok;
  logic [W-1:0] h_last, v_last;
  logic [W-1:0] nh_sync_start, nh_back_start, nv_sync_start, nv_back_start;

  assign cfg_in = '{
    ha: cfg_h_active, hf: cfg_h_front, hs: cfg_h_sync, hb: cfg_h_back,
    va: cfg_v_active, vf: cfg_v_front, vs: cfg_v_sync, vb: cfg_v_back
  };

  // Totals carry two extra bits so that even four maximal fields cannot wrap
  // back into range and slip past the overflow check.
  assign cfg_h_total = (W+2)'(cfg_h_active) + (W+2)'(cfg_h_front)
                     + (W+2)'(cfg_h_sync)   + (W+2)'(cfg_h_back);
  assign cfg_v_total = (W+2)'(cfg_v_active) + (W+2)'(cfg_v_front)
                     + (W+2)'(cfg_v_sync)   + (W+2)'(cfg_v_back);

  assign cfg_ok = (cfg_h_active != '0) && (cfg_h_sync != '0) &&
                  (cfg_v_active != '0) && (cfg_v_sync != '0) &&
                  (cfg_h_total <= TOTAL_MAX) && (cfg_v_total <= TOTAL_MAX);

  // Wrap points come from the timing in force for the current frame.
  // Accepted timings always fit in W bits, so W-bit sums are exact here.
  assign h_last = act_q.ha + act_q.hf + act_q.hs + act_q.hb - ONE;
  assign v_last = act_q.va + act_q.vf + act_q.vs + act_q.vb - ONE;

  // Region boundaries use the timing of the pixel about to be presented.
  // This makes the first pixel after an apply use the new timing.
  assign nh_sync_start = act_d.ha + act_d.hf;
  assign nh_back_start = nh_sync_start + act_d.hs;
  assign nv_sync_start = act_d.va + act_d.vf;
  assign nv_back_start = nv_sync_start + act_d.vs;

  // Position sequencing, the cfg handshake and the frame-boundary apply.
  // cfg_ready_q doubles as "shadow empty", so a transfer and an apply can
  // never coincide.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    act_d       = act_q;
    shd_d       = shd_q;
    cfg_ready_d = cfg_ready_q;
    cfg_err_d   = 1'b0;
    new_frame   = 1'b0;

    if (cfg_valid && cfg_ready_q) begin
      if (cfg_ok) begin
        shd_d       = cfg_in;
        cfg_ready_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (en) begin
      if (state_q == ST_IDLE) begin
        state_d   = ST_RUN;
        row_d     = '0;
        col_d     = '0;
        new_frame = 1'b1;
      end else if (col_q == h_last) begin
        col_d = '0;
        if (row_q == v_last) begin
          row_d     = '0;
          new_frame = 1'b1;
        end else begin
          row_d = row_q + ONE;
        end
      end else begin
        col_d = col_q + ONE;
      end

      if (new_frame && !cfg_ready_q) begin
        act_d       = shd_q;
        cfg_ready_d = 1'b1;
      end
    end
  end

  // Flags, pins and strobes are computed for the position being loaded, so
  // they line up with row/col in the same output cycle. With en low they
  // hold, and a strobe that was high stays high.
  always_comb begin
    hfront_d      = hfront_q;
    hsync_d       = hsync_q;
    hback_d       = hback_q;
    vfront_d      = vfront_q;
    vsync_d       = vsync_q;
    vback_d       = vback_q;
    indisplay_d   = indisplay_q;
    hsync_pin_d   = hsync_pin_q;
    vsync_pin_d   = vsync_pin_q;
    frame_start_d = frame_start_q;
    line_start_d  = line_start_q;

    if (en) begin
      indisplay_d   = (col_d < act_d.ha) && (row_d < act_d.va);
      hfront_d      = (col_d >= act_d.ha) && (col_d < nh_sync_start);
      hsync_d       = (col_d >= nh_sync_start) && (col_d < nh_back_start);
      hback_d       = (col_d >= nh_back_start);
      vfront_d      = (row_d >= act_d.va) && (row_d < nv_sync_start);
      vsync_d       = (row_d >= nv_sync_start) && (row_d < nv_back_start);
      vback_d       = (row_d >= nv_back_start);
      hsync_pin_d   = hsync_d ? HSYNC_POL : ~HSYNC_POL;
      vsync_pin_d   = vsync_d ? VSYNC_POL : ~VSYNC_POL;
      frame_start_d = (row_d == '0) && (col_d == '0);
      line_start_d  = (col_d == '0);
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      act_q         <= DEF_TIMING;
      shd_q         <= '0;
      cfg_ready_q   <= 1'b1;
      cfg_err_q     <= 1'b0;
      hfront_q      <= 1'b0;
      hsync_q       <= 1'b0;
      hback_q       <= 1'b0;
      vfront_q      <= 1'b0;
      vsync_q       <= 1'b0;
      vback_q       <= 1'b0;
      indisplay_q   <= 1'b0;
      hsync_pin_q   <= ~HSYNC_POL;
      vsync_pin_q   <= ~VSYNC_POL;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      act_q         <= act_d;
      shd_q         <= shd_d;
      cfg_ready_q   <= cfg_ready_d;
      cfg_err_q     <= cfg_err_d;
      hfront_q      <= hfront_d;
      hsync_q       <= hsync_d;
      hback_q       <= hback_d;
      vfront_q      <= vfront_d;
      vsync_q       <= vsync_d;
      vback_q       <= vback_d;
      indisplay_q   <= indisplay_d;
      hsync_pin_q   <= hsync_pin_d;
      vsync_pin_q   <= vsync_pin_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign cfg_err     = cfg_err_q;
  assign hfront      = hfront_q;
  assign hsync       = hsync_q;
  assign hback       = hback_q;
  assign vfront      = vfront_q;
  assign vsync       = vsync_q;
  assign vback       = vback_q;
  assign indisplay   = indisplay_q;
  assign hsync_pin   = hsync_pin_q;
  assign vsync_pin   = vsync_pin_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign row         = row_q;
  assign col         = col_q;

endmodule

// File: tb/tb_display_timing.sv
// ---------------------------------------------------------------------------
// tb_display_timing
//   Directed bench for display_timing. The horizontal timing is the 640x480
//   line (800 pixels). The vertical default is shortened to 4/1/2/1 lines
//   (8-line frame, 6400 pixels) so that frame wraps and cfg applies happen
//   within a short run. A behavioural model pushes the expected outputs for
//   each clock into a queue. The queue is popped and compared one time unit
//   after the edge. Extra directed checks compare against hand-derived
//   constants.
// ---------------------------------------------------------------------------
module tb_display_timing;

  localparam int W = 16;
  localparam int DEF_T[8] = '{640, 16, 96, 48, 4, 1, 2, 1};

  logic         pixelclk = 1'b0;
  logic         rst_n, en, cfg_valid;
  logic [W-1:0] cfg_f[8];
  logic         cfg_ready, cfg_err;
  logic         hfront, hsync, hback, vfront, vsync, vback, indisplay;
  logic         hsync_pin, vsync_pin, frame_start, line_start;
  logic [W-1:0] row, col;

  typedef struct packed {
    logic         cfg_ready;
    logic         cfg_err;
    logic         hfront;
    logic         hsync;
    logic         hback;
    logic         vfront;
    logic         vsync;
    logic         vback;
    logic         indisplay;
    logic         hsync_pin;
    logic         vsync_pin;
    logic         frame_start;
    logic         line_start;
    logic [W-1:0] row;
    logic [W-1:0] col;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  bit   m_run;
  bit   m_pend;
  int   m_row, m_col;
  int   m_tim[8];
  int   m_shd[8];
  obs_t m_out;

  always #5 pixelclk = ~pixelclk;

  display_timing #(
    .W(W),
    .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_ACTIVE(4),   .V_FRONT(1),  .V_SYNC(2),  .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .pixelclk(pixelclk), .rst_n(rst_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_active(cfg_f[0]), .cfg_h_front(cfg_f[1]),
    .cfg_h_sync(cfg_f[2]),   .cfg_h_back(cfg_f[3]),
    .cfg_v_active(cfg_f[4]), .cfg_v_front(cfg_f[5]),
    .cfg_v_sync(cfg_f[6]),   .cfg_v_back(cfg_f[7]),
    .cfg_err(cfg_err),
    .hfront(hfront), .hsync(hsync), .hback(hback),
    .vfront(vfront), .vsync(vsync), .vback(vback),
    .indisplay(indisplay), .hsync_pin(hsync_pin), .vsync_pin(vsync_pin),
    .frame_start(frame_start), .line_start(line_start),
    .row(row), .col(col)
  );

  function automatic obs_t sampleDut();
    obs_t o;
    o.cfg_ready   = cfg_ready;
    o.cfg_err     = cfg_err;
    o.hfront      = hfront;
    o.hsync       = hsync;
    o.hback       = hback;
    o.vfront      = vfront;
    o.vsync       = vsync;
    o.vback       = vback;
    o.indisplay   = indisplay;
    o.hsync_pin   = hsync_pin;
    o.vsync_pin   = vsync_pin;
    o.frame_start = frame_start;
    o.line_start  = line_start;
    o.row         = row;
    o.col         = col;
    return o;
  endfunction

  // Advances the model by one clock and queues the outputs expected after it.
  task automatic modelStep(input logic r, input logic e, input logic cv);
    int  htot, vtot, ch, cvt;
    int  hs0, hb0, vs0, vb0;
    bit  pend_old, new_frame;
    pend_old = m_pend;
    if (!r) begin
      m_run  = 1'b0;
      m_pend = 1'b0;
      m_row  = 0;
      m_col  = 0;
      m_tim  = DEF_T;
      m_out  = '0;
      m_out.hsync_pin = 1'b1;
      m_out.vsync_pin = 1'b1;
      m_out.cfg_ready = 1'b1;
    end else begin
      m_out.cfg_err = 1'b0;
      if (cv && !pend_old) begin
        ch  = int'(cfg_f[0]) + int'(cfg_f[1]) + int'(cfg_f[2]) + int'(cfg_f[3]);
        cvt = int'(cfg_f[4]) + int'(cfg_f[5]) + int'(cfg_f[6]) + int'(cfg_f[7]);
        if (cfg_f[0] == 0 || cfg_f[2] == 0 || cfg_f[4] == 0 || cfg_f[6] == 0 ||
            ch > 65535 || cvt > 65535) begin
          m_out.cfg_err = 1'b1;
        end else begin
          for (int i = 0; i < 8; i++) m_shd[i] = int'(cfg_f[i]);
          m_pend = 1'b1;
        end
      end
      if (e) begin
        htot = m_tim[0] + m_tim[1] + m_tim[2] + m_tim[3];
        vtot = m_tim[4] + m_tim[5] + m_tim[6] + m_tim[7];
        new_frame = 1'b0;
        if (!m_run) begin
          m_run = 1'b1;
          m_row = 0;
          m_col = 0;
          new_frame = 1'b1;
        end else if (m_col == htot - 1) begin
          m_col = 0;
          if (m_row == vtot - 1) begin
            m_row = 0;
            new_frame = 1'b1;
          end else begin
            m_row++;
          end
        end else begin
          m_col++;
        end
        if (new_frame && pend_old) begin
          m_tim  = m_shd;
          m_pend = 1'b0;
        end
        hs0 = m_tim[0] + m_tim[1];
        hb0 = hs0 + m_tim[2];
        vs0 = m_tim[4] + m_tim[5];
        vb0 = vs0 + m_tim[6];
        m_out.row         = W'(m_row);
        m_out.col         = W'(m_col);
        m_out.indisplay   = (m_col < m_tim[0]) && (m_row < m_tim[4]);
        m_out.hfront      = (m_col >= m_tim[0]) && (m_col < hs0);
        m_out.hsync       = (m_col >= hs0) && (m_col < hb0);
        m_out.hback       = (m_col >= hb0);
        m_out.vfront      = (m_row >= m_tim[4]) && (m_row < vs0);
        m_out.vsync       = (m_row >= vs0) && (m_row < vb0);
        m_out.vback       = (m_row >= vb0);
        m_out.hsync_pin   = !m_out.hsync;
        m_out.vsync_pin   = !m_out.vsync;
        m_out.frame_start = (m_row == 0) && (m_col == 0);
        m_out.line_start  = (m_col == 0);
      end
      m_out.cfg_ready = !m_pend;
    end
    exp_q.push_back(m_out);
  endtask

  task automatic checkOutput(input string tag);
    obs_t e, o;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s scoreboard empty", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = sampleDut();
      assert (o === e) else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic cv,
                               input string tag);
    rst_n     = r;
    en        = e;
    cfg_valid = cv;
    modelStep(r, e, cv);
    @(posedge pixelclk);
    #1;
    checkOutput(tag);
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, tag);
  endtask

  task automatic setCfg(input int ha, input int hf, input int hs, input int hb,
                        input int va, input int vf, input int vs, input int vb);
    cfg_f[0] = W'(ha); cfg_f[1] = W'(hf); cfg_f[2] = W'(hs); cfg_f[3] = W'(hb);
    cfg_f[4] = W'(va); cfg_f[5] = W'(vf); cfg_f[6] = W'(vs); cfg_f[7] = W'(vb);
  endtask

  initial begin
    bit saw_hfront;
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    setCfg(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, "reset");
    checkValue("rst_hsync_pin", hsync_pin, 1);
    checkValue("rst_vsync_pin", vsync_pin, 1);
    checkValue("rst_indisplay", indisplay, 0);
    checkValue("rst_cfg_ready", cfg_ready, 1);

    $display("[TB] release and first frame");
    applyStimulus(1'b1, 1'b1, 1'b0, "first_run");
    checkValue("first_row", row, 0);
    checkValue("first_col", col, 0);
    checkValue("first_indisplay", indisplay, 1);
    checkValue("first_frame_start", frame_start, 1);
    checkValue("first_line_start", line_start, 1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, "hold_strobe");
    checkValue("held_frame_start", frame_start, 1);

    runCycles(655, "to_655");
    checkValue("col_655", col, 655);
    checkValue("hsync_655", hsync, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, "en_low");
    checkValue("frozen_col", col, 655);
    checkValue("frozen_hsync", hsync, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, "resume");
    checkValue("resume_hsync", hsync, 1);
    checkValue("resume_hsync_pin", hsync_pin, 0);
    runCycles(95, "sync");
    checkValue("hsync_751", hsync, 1);
    runCycles(1, "sync_end");
    checkValue("hsync_752", hsync, 0);
    checkValue("hback_752", hback, 1);
    runCycles(48, "line_wrap");
    checkValue("wrap_row", row, 1);
    checkValue("wrap_col", col, 0);
    runCycles(2400, "to_row4");
    checkValue("row4_vfront", vfront, 1);
    runCycles(800, "to_row5");
    checkValue("row5_vsync", vsync, 1);
    checkValue("row5_vsync_pin", vsync_pin, 0);
    runCycles(1600, "to_row7");
    checkValue("row7_vback", vback, 1);
    runCycles(800, "frame_wrap");
    checkValue("frame2_start", frame_start, 1);

    $display("[TB] mid-frame reconfiguration");
    runCycles(100, "frame2");
    setCfg(4, 1, 2, 1, 3, 1, 1, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, "cfg_small");
    checkValue("cfg_pending_ready", cfg_ready, 0);
    runCycles(6298, "frame2_rest");
    checkValue("old_last_row", row, 7);
    checkValue("old_last_col", col, 799);
    checkValue("old_last_ready", cfg_ready, 0);
    runCycles(1, "apply");
    checkValue("apply_ready", cfg_ready, 1);
    checkValue("apply_frame_start", frame_start, 1);
    runCycles(5, "small_h");
    checkValue("small_hsync_5", hsync, 1);
    runCycles(1, "small_h");
    checkValue("small_hsync_6", hsync, 1);
    runCycles(1, "small_h");
    checkValue("small_hsync_7", hsync, 0);
    runCycles(25, "small_v");
    checkValue("small_row4", row, 4);
    checkValue("small_vsync", vsync, 1);
    runCycles(16, "small_wrap");
    checkValue("small_frame_start", frame_start, 1);

    $display("[TB] rejected and porch-free configs");
    setCfg(4, 1, 0, 1, 3, 1, 1, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, "cfg_hsync0");
    checkValue("err_hsync0", cfg_err, 1);
    checkValue("err_ready", cfg_ready, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, "err_gap");
    checkValue("err_pulse_end", cfg_err, 0);
    setCfg(65535, 1, 1, 1, 3, 1, 1, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, "cfg_hovf");
    checkValue("err_hovf", cfg_err, 1);
    setCfg(4, 1, 2, 1, 3, 1, 1, 65535);
    applyStimulus(1'b1, 1'b1, 1'b1, "cfg_vovf");
    checkValue("err_vovf", cfg_err, 1);
    setCfg(4, 0, 2, 1, 3, 1, 1, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, "cfg_nofront");
    checkValue("nofront_accepted", cfg_ready, 0);
    runCycles(42, "to_small_end");
    checkValue("small_last_row", row, 5);
    checkValue("small_last_col", col, 7);
    runCycles(1, "apply_nofront");
    checkValue("nofront_ready", cfg_ready, 1);
    saw_hfront = 1'b0;
    for (int i = 0; i < 84; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, "nofront_run");
      saw_hfront |= hfront;
    end
    checkValue("nofront_never", saw_hfront, 0);
    checkValue("nofront_frame_start", frame_start, 1);

    $display("[TB] reset with pending shadow");
    runCycles(10, "pre_reset");
    setCfg(4, 1, 2, 1, 3, 1, 1, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, "cfg_before_reset");
    runCycles(3, "pending");
    checkValue("pending_ready", cfg_ready, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, "mid_reset");
    checkValue("mid_reset_ready", cfg_ready, 1);
    checkValue("mid_reset_hsync_pin", hsync_pin, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, "restart");
    checkValue("restart_frame_start", frame_start, 1);
    runCycles(799, "default_line");
    checkValue("default_col_799", col, 799);
    runCycles(1, "default_wrap");
    checkValue("default_wrap_row", row, 1);
    checkValue("default_wrap_col", col, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
